// File: rtl/sd_sector_arbiter.sv
// Round-robin arbiter sharing one HPS sector-transfer channel between NDRIVE floppy drives.
// Optional ISSUE-phase ack timeout is compiled in with `define SDARB_TIMEOUT_EN.
module sd_sector_arbiter #(
  parameter int NDRIVE  = 4,
  parameter int TIMEOUT = 1 << 22
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [NDRIVE-1:0]     drv_rd,
  input  logic [NDRIVE-1:0]     drv_wr,
  input  logic [32*NDRIVE-1:0]  drv_lba,
  input  logic [8*NDRIVE-1:0]   drv_buff_din,
  output logic [NDRIVE-1:0]     drv_done,
  output logic [NDRIVE-1:0]     drv_err,
  output logic [NDRIVE-1:0]     drv_buff_wr,
  output logic                  busy,
  output logic [31:0]           sd_lba,
  output logic [NDRIVE-1:0]     sd_rd,
  output logic [NDRIVE-1:0]     sd_wr,
  input  logic [NDRIVE-1:0]     sd_ack,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din
);

  localparam int GW = (NDRIVE > 1) ? $clog2(NDRIVE) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;

  logic [2:0]        state, state_nx;
  logic [GW-1:0]     ptr, g, pick;
  logic              found;
  logic              op_wr;
  logic              tmo;
  logic [NDRIVE-1:0] req;

  assign req = drv_rd | drv_wr;

  // First requester at or after ptr; scanning downwards lets the lowest offset win.
  always_comb begin
    int idx;
    pick  = ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = NDRIVE - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NDRIVE) idx = idx - NDRIVE;
      if (req[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (found) state_nx = ISSUE;
      ISSUE: begin
        if (sd_ack[g])  state_nx = XFER;
        else if (tmo)   state_nx = ABORT;
      end
      XFER:  if (!sd_ack[g]) state_nx = DONE;
      DONE:  state_nx = IDLE;
      ABORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      g        <= '0;
      op_wr    <= 1'b0;
      sd_lba   <= '0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      drv_done <= '0;
      busy     <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      if (state == IDLE && found) begin
        g      <= pick;
        op_wr  <= drv_wr[pick];
        sd_lba <= drv_lba[32*pick +: 32];
      end
      // Strobe is held only while ISSUE persists, so it drops on the ack/abort edge.
      sd_rd <= '0;
      sd_wr <= '0;
      if (state == ISSUE && state_nx == ISSUE) begin
        if (op_wr) sd_wr[g] <= 1'b1;
        else       sd_rd[g] <= 1'b1;
      end
      drv_done <= '0;
      if (state_nx == DONE) drv_done[g] <= 1'b1;
      if (state == DONE || state == ABORT) begin
        ptr <= (int'(g) == NDRIVE - 1) ? '0 : g + GW'(1);
      end
    end
  end

`ifdef SDARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  assign tmo = (tcnt == TW'(TIMEOUT));

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tcnt    <= '0;
      drv_err <= '0;
    end else begin
      if (state == ISSUE) tcnt <= tcnt + TW'(1);
      else                tcnt <= '0;
      drv_err <= '0;
      if (state_nx == ABORT) drv_err[g] <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign drv_err = '0;
`endif

  always_comb begin
    drv_buff_wr = '0;
    if (state == XFER) drv_buff_wr[g] = sd_buff_wr;
    sd_buff_din = (state == IDLE) ? 8'h00 : drv_buff_din[8*g +: 8];
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed scoreboard bench for sd_sector_arbiter (NDRIVE=4, TIMEOUT=16).
module tb_sd_sector_arbiter;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] lba;
    logic [7:0]  din;
  } exp_t;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic [3:0]   drv_rd, drv_wr, sd_ack;
  logic [127:0] drv_lba;
  logic [31:0]  drv_buff_din;
  logic [3:0]   drv_done, drv_err, drv_buff_wr, sd_rd, sd_wr;
  logic         busy, sd_buff_wr;
  logic [31:0]  sd_lba;
  logic [7:0]   sd_buff_din;

  int   vectors = 0;
  int   miscompares = 0;
  int   err_seen = 0;
  exp_t q[$];

  always #5 clk_sys = ~clk_sys;

  sd_sector_arbiter #(.NDRIVE(4), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_lba(drv_lba), .drv_buff_din(drv_buff_din), .drv_done(drv_done), .drv_err(drv_err),
    .drv_buff_wr(drv_buff_wr), .busy(busy), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  always @(negedge clk_sys) if (drv_err !== 4'b0000) err_seen++;

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] rd, input logic [3:0] wr, input int d);
    exp_t e;
    e.rd  = rd;
    e.wr  = wr;
    e.lba = drv_lba[32*d +: 32];
    e.din = drv_buff_din[8*d +: 8];
    q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sd_rd"}, sd_rd, 4'b0);
    check({tag, "_sd_wr"}, sd_wr, 4'b0);
    check({tag, "_sd_lba"}, sd_lba, 32'h0);
    check({tag, "_done"}, drv_done, 4'b0);
    check({tag, "_err"}, drv_err, 4'b0);
    check({tag, "_buff_wr"}, drv_buff_wr, 4'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_buff_din"}, sd_buff_din, 8'h0);
  endtask

  // Plays the HPS side for one transfer and checks it against the next scoreboard entry.
  task automatic serve(input int delay, input int nbytes, input bit keep, input bit stray);
    exp_t e;
    int t, gi, cnt_g, cnt_other;
    logic [3:0] oh;
    t = 0;
    while ((sd_rd | sd_wr) == 4'b0 && t < 100) begin
      tick;
      t++;
    end
    check("strobe_seen", (t < 100), 1'b1);
    e = q.pop_front();
    oh = e.rd | e.wr;
    gi = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) gi = i;
    check("sd_rd", sd_rd, e.rd);
    check("sd_wr", sd_wr, e.wr);
    check("sd_lba", sd_lba, e.lba);
    check("busy_issue", busy, 1'b1);
    if (stray) begin
      sd_ack = 4'b0100;
      tick;
      tick;
      check("stray_strobe", sd_rd | sd_wr, oh);
      sd_ack = 4'b0000;
    end
    repeat (delay) tick;
    check("strobe_hold", sd_rd | sd_wr, oh);
    sd_ack[gi] = 1'b1;
    tick;
    check("strobe_drop", sd_rd | sd_wr, 4'b0);
    cnt_g = 0;
    cnt_other = 0;
    for (int b = 0; b < nbytes; b++) begin
      sd_buff_wr = 1'b1;
      #1;
      if (drv_buff_wr[gi]) cnt_g++;
      if ((drv_buff_wr & ~oh) != 4'b0) cnt_other++;
      if (b == 0) check("buff_din", sd_buff_din, e.din);
      tick;
      sd_buff_wr = 1'b0;
    end
    check("buff_wr_count", cnt_g, nbytes);
    check("buff_wr_other", cnt_other, 0);
    sd_ack[gi] = 1'b0;
    tick;
    check("done_pulse", drv_done, oh);
    if (!keep) begin
      drv_rd = 4'b0;
      drv_wr = 4'b0;
    end
    tick;
    check("done_single", drv_done, 4'b0);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    int t;
    reset_n      = 1'b0;
    drv_rd       = 4'b0;
    drv_wr       = 4'b0;
    sd_ack       = 4'b0;
    sd_buff_wr   = 1'b0;
    drv_lba      = {32'h0000_1003, 32'h0000_1002, 32'h0000_0123, 32'h0000_1000};
    drv_buff_din = 32'h3C_A5_22_11;
    tick;
    tick;
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick;

    // Single read on drive 1, 512 bytes
    drv_rd = 4'b0010;
    push(4'b0010, 4'b0000, 1);
    serve(3, 512, 1'b0, 1'b0);

    // Round-robin from a fresh reset
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    drv_lba[63:32] = 32'h0000_1001;
    drv_rd = 4'b1111;
    push(4'b0001, 4'b0, 0);
    push(4'b0010, 4'b0, 1);
    push(4'b0100, 4'b0, 2);
    push(4'b1000, 4'b0, 3);
    push(4'b0001, 4'b0, 0);
    for (int i = 0; i < 4; i++) serve(1, 4, 1'b1, 1'b0);
    serve(1, 4, 1'b0, 1'b0);

    // Read/write collision on drive 2: write wins
    drv_rd = 4'b0100;
    drv_wr = 4'b0100;
    push(4'b0000, 4'b0100, 2);
    serve(2, 3, 1'b0, 1'b0);

    // Stray ack on drive 2 while drive 0 is in ISSUE
    drv_rd = 4'b0001;
    push(4'b0001, 4'b0000, 0);
    serve(1, 2, 1'b0, 1'b1);

    // Reset during drive 3 transfer
    drv_rd = 4'b1000;
    push(4'b1000, 4'b0000, 3);
    t = 0;
    while (sd_rd == 4'b0 && t < 100) begin
      tick;
      t++;
    end
    check("rst_strobe_seen", (t < 100), 1'b1);
    begin
      exp_t e;
      e = q.pop_front();
      check("rst_sd_rd", sd_rd, e.rd);
      check("rst_sd_lba", sd_lba, e.lba);
    end
    sd_ack[3] = 1'b1;
    tick;
    sd_buff_wr = 1'b1;
    drv_rd = 4'b0;
    tick;
    reset_n = 1'b0;
    tick;
    #1;
    check_idle_outputs("mid_reset");
    reset_n = 1'b1;
    sd_ack = 4'b0;
    sd_buff_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("no_done_after_reset", drv_done, 4'b0);
    end
    drv_rd = 4'b1001;
    push(4'b0001, 4'b0, 0);
    push(4'b1000, 4'b0, 3);
    serve(1, 1, 1'b1, 1'b0);
    serve(1, 1, 1'b0, 1'b0);

`ifdef SDARB_TIMEOUT_EN
    drv_rd = 4'b0001;
    t = 0;
    while (sd_rd == 4'b0 && t < 100) begin
      tick;
      t++;
    end
    check("tmo_strobe_seen", (t < 100), 1'b1);
    t = 0;
    while (drv_err == 4'b0 && t < 40) begin
      tick;
      t++;
    end
    check("tmo_delay", t, 16);
    check("tmo_err", drv_err, 4'b0001);
    check("tmo_sd_rd", sd_rd, 4'b0);
    drv_rd = 4'b0;
    tick;
    check("tmo_err_single", drv_err, 4'b0);
    check("tmo_busy", busy, 1'b0);
`else
    check("no_err_ever", err_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
